// File: rtl/alu_pkg.sv
// Shared definitions for the ALU stage: opcode encodings, flag bit positions
// inside FlagsOut, and the control FSM state encoding.
package alu_pkg;

    localparam logic [3:0] OP_PASSA = 4'h0;
    localparam logic [3:0] OP_PASSB = 4'h1;
    localparam logic [3:0] OP_NOTA  = 4'h2;
    localparam logic [3:0] OP_NOTB  = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_ADC   = 4'h5;
    localparam logic [3:0] OP_SUB   = 4'h6;
    localparam logic [3:0] OP_AND   = 4'h7;
    localparam logic [3:0] OP_OR    = 4'h8;
    localparam logic [3:0] OP_XOR   = 4'h9;
    localparam logic [3:0] OP_LSL   = 4'hA;
    localparam logic [3:0] OP_LSR   = 4'hB;
    localparam logic [3:0] OP_ASR   = 4'hC;
    localparam logic [3:0] OP_CSL   = 4'hD;
    localparam logic [3:0] OP_CSR   = 4'hE;
    localparam logic [3:0] OP_MUL   = 4'hF;

    // FlagsOut is packed as {Z,C,N,O}
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier sequencer: one partial-product step per enabled cycle,
// WIDTH steps per multiplication. Only the low WIDTH bits are kept.
// 'product' is the accumulator value after the current step, so the caller
// can register the finished result on the same edge that performs the last step.
module alu_mul_seq import alu_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             step,
    output logic [WIDTH-1:0] product,
    output logic             last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;

    assign product = acc + (mplier[0] ? mcand : '0);
    assign last    = (count == CW'(WIDTH - 1));

    // Latch operands on load, then add/shift once per step while counting steps
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (load) begin
            mcand  <= A;
            mplier <= B;
            acc    <= '0;
            count  <= '0;
        end else if (step) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
        end
    end

endmodule

// File: rtl/alu_stage.sv
// Registered ALU stage fed by the register file read ports.
// Single-cycle ops land in ALUOut one edge after Start; the optional
// multi-cycle MUL (enabled by defining ALU_MUL_EN) holds Busy for WIDTH cycles.
// Without ALU_MUL_EN, FunSel=F is a single-cycle op that returns zero.
module alu_stage import alu_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       FunSel,
    input  logic             Start,
    input  logic             WF,
    output logic [WIDTH-1:0] ALUOut,
    output logic [3:0]       FlagsOut,
    output logic             Busy,
    output logic             Done
);

    state_t           state;
    state_t           state_next;
    logic             wf_lat;
    logic             wf_use;
    logic             mul_sel;
    logic             mul_load;
    logic             mul_step;
    logic [WIDTH-1:0] mul_product;
    logic             mul_last;
    logic [WIDTH-1:0] op_res;
    logic             op_c;
    logic             op_o;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_value;
    logic             res_load;
    logic             flag_c;
    logic             flag_o;
    logic [3:0]       flags_next;

`ifdef ALU_MUL_EN
    assign mul_sel = (FunSel == OP_MUL);
    assign Busy    = (state == S_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .Clock   (Clock),
        .Reset   (Reset),
        .load    (mul_load),
        .A       (A),
        .B       (B),
        .step    (mul_step),
        .product (mul_product),
        .last    (mul_last)
    );
`else
    logic mul_unused;

    assign mul_sel     = 1'b0;
    assign Busy        = 1'b0;
    assign mul_product = '0;
    assign mul_last    = 1'b0;
    assign mul_unused  = mul_load ^ mul_step;
`endif

    // Single-cycle operation mux; C and O default to their current values
    always_comb begin
        op_res = '0;
        op_c   = FlagsOut[FLAG_C];
        op_o   = FlagsOut[FLAG_O];
        sum    = '0;
        case (FunSel)
            OP_PASSA: op_res = A;
            OP_PASSB: op_res = B;
            OP_NOTA:  op_res = ~A;
            OP_NOTB:  op_res = ~B;
            OP_ADD: begin
                sum    = {1'b0, A} + {1'b0, B};
                op_res = sum[WIDTH-1:0];
                op_c   = sum[WIDTH];
                op_o   = (A[WIDTH-1] == B[WIDTH-1]) && (op_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_ADC: begin
                sum    = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, FlagsOut[FLAG_C]};
                op_res = sum[WIDTH-1:0];
                op_c   = sum[WIDTH];
                op_o   = (A[WIDTH-1] == B[WIDTH-1]) && (op_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                // Two's complement subtract: carry-out is set when no borrow occurs
                sum    = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
                op_res = sum[WIDTH-1:0];
                op_c   = sum[WIDTH];
                op_o   = (A[WIDTH-1] != B[WIDTH-1]) && (op_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: op_res = A & B;
            OP_OR:  op_res = A | B;
            OP_XOR: op_res = A ^ B;
            OP_LSL: begin
                op_res = {A[WIDTH-2:0], 1'b0};
                op_c   = A[WIDTH-1];
            end
            OP_LSR: begin
                op_res = {1'b0, A[WIDTH-1:1]};
                op_c   = A[0];
            end
            OP_ASR: begin
                op_res = {A[WIDTH-1], A[WIDTH-1:1]};
                op_c   = A[0];
                op_o   = 1'b0;
            end
            OP_CSL: begin
                op_res = {A[WIDTH-2:0], FlagsOut[FLAG_C]};
                op_c   = A[WIDTH-1];
            end
            OP_CSR: begin
                op_res = {FlagsOut[FLAG_C], A[WIDTH-1:1]};
                op_c   = A[0];
            end
            default: op_res = '0;
        endcase
    end

    // Control FSM: launches ops from IDLE and retires the multiplier result
    always_comb begin
        state_next = state;
        mul_load   = 1'b0;
        mul_step   = 1'b0;
        res_load   = 1'b0;
        res_value  = op_res;
        flag_c     = op_c;
        flag_o     = op_o;
        wf_use     = WF;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    if (mul_sel) begin
                        mul_load   = 1'b1;
                        state_next = S_MUL;
                    end else begin
                        res_load = 1'b1;
                    end
                end
            end
            S_MUL: begin
                mul_step  = 1'b1;
                wf_use    = wf_lat;
                res_value = mul_product;
                flag_c    = FlagsOut[FLAG_C];
                flag_o    = FlagsOut[FLAG_O];
                if (mul_last) begin
                    res_load   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        flags_next         = '0;
        flags_next[FLAG_Z] = (res_value == '0);
        flags_next[FLAG_C] = flag_c;
        flags_next[FLAG_N] = res_value[WIDTH-1];
        flags_next[FLAG_O] = flag_o;
    end

    // State register plus the write-flags enable captured when MUL launches
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state  <= S_IDLE;
            wf_lat <= 1'b0;
        end else begin
            state <= state_next;
            if (mul_load) begin
                wf_lat <= WF;
            end
        end
    end

    // Output registers: result, flags (only when enabled) and the Done pulse
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ALUOut   <= '0;
            FlagsOut <= '0;
            Done     <= 1'b0;
        end else begin
            Done <= res_load;
            if (res_load) begin
                ALUOut <= res_value;
                if (wf_use) begin
                    FlagsOut <= flags_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_stage.sv
// Self-checking bench for alu_stage. A table of single-cycle vectors is issued
// back-to-back with flags carried from one vector to the next; hand-written
// sequences cover asynchronous reset and the FunSel=F behaviour of the build
// (multi-cycle MUL when ALU_MUL_EN is defined, zero result otherwise).
module tb_alu_stage;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  fs;
        logic        wf;
        logic [15:0] out;
        logic [3:0]  flags;
    } vec_t;

    logic        Clock;
    logic        Reset;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  FunSel;
    logic        Start;
    logic        WF;
    logic [15:0] ALUOut;
    logic [3:0]  FlagsOut;
    logic        Busy;
    logic        Done;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    alu_stage #(.WIDTH(16)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .A        (A),
        .B        (B),
        .FunSel   (FunSel),
        .Start    (Start),
        .WF       (WF),
        .ALUOut   (ALUOut),
        .FlagsOut (FlagsOut),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] fs, input logic wf, input logic st);
        A      = a;
        B      = b;
        FunSel = fs;
        WF     = wf;
        Start  = st;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string name, input logic [15:0] out, input logic [3:0] flags,
                            input logic busy, input logic done);
        checkOutput({name, "_out"},   {16'h0, ALUOut},   {16'h0, out});
        checkOutput({name, "_flags"}, {28'h0, FlagsOut}, {28'h0, flags});
        checkOutput({name, "_busy"},  {31'h0, Busy},     {31'h0, busy});
        checkOutput({name, "_done"},  {31'h0, Done},     {31'h0, done});
    endtask

    initial begin
        Reset = 1'b0;
        applyStimulus(16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
        #2;
        checkAll("reset_init", 16'h0000, 4'b0000, 1'b0, 1'b0);
        @(negedge Clock);
        Reset = 1'b1;

        // Flags are {Z,C,N,O}; each row starts from the flags left by the row above
        vecs.push_back('{16'h7FFF, 16'h0001, 4'h4, 1'b1, 16'h8000, 4'b0011});
        vecs.push_back('{16'h0003, 16'h0005, 4'h6, 1'b1, 16'hFFFE, 4'b0010});
        vecs.push_back('{16'h0003, 16'h0005, 4'h6, 1'b0, 16'hFFFE, 4'b0010});
        vecs.push_back('{16'hFFFF, 16'h0001, 4'h4, 1'b1, 16'h0000, 4'b1100});
        vecs.push_back('{16'h0001, 16'h0001, 4'h5, 1'b1, 16'h0003, 4'b0000});
        vecs.push_back('{16'h8001, 16'h0000, 4'hA, 1'b1, 16'h0002, 4'b0100});
        vecs.push_back('{16'h8001, 16'h0000, 4'hD, 1'b1, 16'h0003, 4'b0100});
        vecs.push_back('{16'h0001, 16'h0000, 4'hB, 1'b1, 16'h0000, 4'b1100});
        vecs.push_back('{16'h0002, 16'h0000, 4'hE, 1'b1, 16'h8001, 4'b0010});
        vecs.push_back('{16'h8000, 16'h0001, 4'h6, 1'b1, 16'h7FFF, 4'b0101});
        vecs.push_back('{16'h8005, 16'h0000, 4'hC, 1'b1, 16'hC002, 4'b0110});
        vecs.push_back('{16'h1234, 16'h0000, 4'h0, 1'b1, 16'h1234, 4'b0100});
        vecs.push_back('{16'h1234, 16'h0000, 4'h1, 1'b1, 16'h0000, 4'b1100});
        vecs.push_back('{16'h0F0F, 16'h0000, 4'h2, 1'b1, 16'hF0F0, 4'b0110});
        vecs.push_back('{16'h0000, 16'hFFFF, 4'h3, 1'b1, 16'h0000, 4'b1100});
        vecs.push_back('{16'hFF00, 16'h0FF0, 4'h7, 1'b1, 16'h0F00, 4'b0100});
        vecs.push_back('{16'hFF00, 16'h00F0, 4'h8, 1'b1, 16'hFFF0, 4'b0110});
        vecs.push_back('{16'hAAAA, 16'hAAAA, 4'h9, 1'b1, 16'h0000, 4'b1100});
        vecs.push_back('{16'hFFFF, 16'h0000, 4'h5, 1'b1, 16'h0000, 4'b1100});
        vecs.push_back('{16'h0005, 16'h0005, 4'h6, 1'b1, 16'h0000, 4'b1100});
        vecs.push_back('{16'h4000, 16'h0000, 4'hA, 1'b1, 16'h8000, 4'b0010});
        vecs.push_back('{16'h8000, 16'h0000, 4'hB, 1'b0, 16'h4000, 4'b0010});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].fs, vecs[i].wf, 1'b1);
            @(negedge Clock);
            checkAll($sformatf("vec%0d", i), vecs[i].out, vecs[i].flags, 1'b0, 1'b1);
        end

        applyStimulus(16'h0000, 16'h0000, 4'h0, 1'b1, 1'b0);
        @(negedge Clock);
        checkAll("idle_hold", 16'h4000, 4'b0010, 1'b0, 1'b0);

        #2;
        Reset = 1'b0;
        #1;
        checkAll("reset_async", 16'h0000, 4'b0000, 1'b0, 1'b0);
        @(negedge Clock);
        Reset = 1'b1;

        applyStimulus(16'hC000, 16'h0000, 4'hA, 1'b1, 1'b1);
        @(negedge Clock);
        checkAll("prime", 16'h8000, 4'b0110, 1'b0, 1'b1);

`ifdef ALU_MUL_EN
        applyStimulus(16'h0012, 16'h0034, 4'hF, 1'b1, 1'b1);
        @(negedge Clock);
        checkAll("mul_launch", 16'h8000, 4'b0110, 1'b1, 1'b0);
        for (int c = 1; c < 16; c++) begin
            if (c == 5) begin
                applyStimulus(16'hFFFF, 16'h0001, 4'h0, 1'b1, 1'b1);
            end else begin
                applyStimulus(16'hFFFF, 16'hFFFF, 4'h0, 1'b0, 1'b0);
            end
            @(negedge Clock);
            checkOutput($sformatf("mul_busy%0d", c), {31'h0, Busy}, 32'h1);
            checkOutput($sformatf("mul_nodone%0d", c), {31'h0, Done}, 32'h0);
        end
        applyStimulus(16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0);
        @(negedge Clock);
        checkAll("mul_done", 16'h03A8, 4'b0100, 1'b0, 1'b1);

        applyStimulus(16'h0000, 16'h0055, 4'h1, 1'b0, 1'b1);
        @(negedge Clock);
        checkAll("after_mul", 16'h0055, 4'b0100, 1'b0, 1'b1);

        applyStimulus(16'h0012, 16'h0034, 4'hF, 1'b1, 1'b1);
        @(negedge Clock);
        checkOutput("abort_launch_busy", {31'h0, Busy}, 32'h1);
        applyStimulus(16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0);
        repeat (7) @(negedge Clock);
        checkOutput("abort_mid_busy", {31'h0, Busy}, 32'h1);
        #2;
        Reset = 1'b0;
        #1;
        checkAll("abort_reset", 16'h0000, 4'b0000, 1'b0, 1'b0);
        @(negedge Clock);
        Reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clock);
            checkOutput($sformatf("abort_nodone%0d", c), {31'h0, Done}, 32'h0);
            checkOutput($sformatf("abort_idle%0d", c), {31'h0, Busy}, 32'h0);
        end
        checkOutput("abort_out", {16'h0, ALUOut}, 32'h0);
`else
        applyStimulus(16'h1234, 16'h5678, 4'hF, 1'b1, 1'b1);
        @(negedge Clock);
        checkAll("mulf_off", 16'h0000, 4'b1100, 1'b0, 1'b1);
        applyStimulus(16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge Clock);
            checkOutput($sformatf("mulf_nobusy%0d", c), {31'h0, Busy}, 32'h0);
            checkOutput($sformatf("mulf_nodone%0d", c), {31'h0, Done}, 32'h0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
